l1_mmu_arbiter: RTL and testbench

//  Shares the single l1mmu request port between L1I (read-only refill) and L1D (refill/writeback).

---
 rtl/l1_mmu_arbiter.sv | 119 +++++++++++
 tb/tb_l1_mmu_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/l1_mmu_arbiter.sv
// Arbitrates the single l1mmu request port between L1I refills and L1D refill/writeback.
// Optional performance counters are compiled in when ARB_PERF_CNT_EN is defined.
module l1_mmu_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int LINE_W       = 256,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [LINE_W-1:0] i_read_data,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_write_data,
  output logic              d_done,
  output logic [LINE_W-1:0] d_read_data,
  output logic              mmu_read,
  output logic              mmu_write,
  output logic [ADDR_W-1:0] mmu_addr,
  output logic [LINE_W-1:0] mmu_write_data,
  input  logic              mmu_done,
  input  logic [LINE_W-1:0] mmu_read_data
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_i_grants,
  output logic [31:0]       perf_d_grants,
  output logic [31:0]       perf_i_wait
`endif
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    RELEASE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;
  logic             d_req;
  logic             grant_i;
  logic             grant_d;

  // D normally wins a tie; once I has been passed over LIMIT times it is forced.
  assign d_req   = d_read | d_write;
  assign grant_i = (state == IDLE) && i_read && (!d_req || (starve_cnt == LIMIT));
  assign grant_d = (state == IDLE) && d_req && !grant_i;

  assign i_done      = (state == BUSY_I) && mmu_done && !rst;
  assign d_done      = (state == BUSY_D) && mmu_done && !rst;
  assign i_read_data = mmu_read_data;
  assign d_read_data = mmu_read_data;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state          <= IDLE;
      starve_cnt     <= '0;
      mmu_read       <= 1'b0;
      mmu_write      <= 1'b0;
      mmu_addr       <= '0;
      mmu_write_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_i) begin
            state          <= BUSY_I;
            starve_cnt     <= '0;
            mmu_read       <= 1'b1;
            mmu_write      <= 1'b0;
            mmu_addr       <= i_addr;
            mmu_write_data <= '0;
          end else if (grant_d) begin
            // A simultaneous read+write is treated as a writeback.
            state          <= BUSY_D;
            mmu_read       <= !d_write;
            mmu_write      <= d_write;
            mmu_addr       <= d_addr;
            mmu_write_data <= d_write_data;
            if (i_read && (starve_cnt != LIMIT))
              starve_cnt <= starve_cnt + 1'b1;
          end
        end
        BUSY_I, BUSY_D: begin
          if (mmu_done) begin
            state     <= RELEASE;
            mmu_read  <= 1'b0;
            mmu_write <= 1'b0;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      perf_i_grants <= '0;
      perf_d_grants <= '0;
      perf_i_wait   <= '0;
    end else begin
      if (grant_i)
        perf_i_grants <= perf_i_grants + 32'd1;
      if (grant_d)
        perf_d_grants <= perf_d_grants + 32'd1;
      if (i_read && (state != BUSY_I))
        perf_i_wait <= perf_i_wait + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_l1_mmu_arbiter.sv
// Randomized bench for l1_mmu_arbiter against a transaction-level model of ownership and fairness.
// Perf counter checks are included when ARB_PERF_CNT_EN is defined.
module tb_l1_mmu_arbiter;
  localparam int ADDR_W       = 32;
  localparam int LINE_W       = 256;
  localparam int STARVE_LIMIT = 4;

  logic              sys_clk = 1'b0;
  logic              rst;
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic              i_done;
  logic [LINE_W-1:0] i_read_data;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_write_data;
  logic              d_done;
  logic [LINE_W-1:0] d_read_data;
  logic              mmu_read;
  logic              mmu_write;
  logic [ADDR_W-1:0] mmu_addr;
  logic [LINE_W-1:0] mmu_write_data;
  logic              mmu_done;
  logic [LINE_W-1:0] mmu_read_data;
`ifdef ARB_PERF_CNT_EN
  logic [31:0]       perf_i_grants;
  logic [31:0]       perf_d_grants;
  logic [31:0]       perf_i_wait;
`endif

  always #5 sys_clk = ~sys_clk;

  l1_mmu_arbiter #(
    .ADDR_W(ADDR_W), .LINE_W(LINE_W), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .sys_clk(sys_clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_done(i_done), .i_read_data(i_read_data),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_write_data(d_write_data),
    .d_done(d_done), .d_read_data(d_read_data),
    .mmu_read(mmu_read), .mmu_write(mmu_write), .mmu_addr(mmu_addr),
    .mmu_write_data(mmu_write_data), .mmu_done(mmu_done), .mmu_read_data(mmu_read_data)
`ifdef ARB_PERF_CNT_EN
    , .perf_i_grants(perf_i_grants), .perf_d_grants(perf_d_grants), .perf_i_wait(perf_i_wait)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Model: who owns the port, what it is doing, and how many idle edges remain before arbitration.
  int                owner;
  int                blocked;
  int                starve;
  bit                after_reset;
  bit                exp_rd;
  bit                exp_wr;
  logic [ADDR_W-1:0] exp_addr;
  logic [LINE_W-1:0] exp_wdata;
  logic [31:0]       exp_ig;
  logic [31:0]       exp_dg;
  logic [31:0]       exp_iw;

  bit force_rst;
  bit rst_on_busy_d;
  bit saw_i_done;
  bit saw_d_done;

  task automatic checkOutput(input string tag, input logic [LINE_W-1:0] got,
                             input logic [LINE_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] r;
    for (int k = 0; k < LINE_W / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic applyStimulus(input int p_i, input int p_d, input int p_rst);
    int op;
    rst = force_rst || ($urandom_range(0, 999) < p_rst) ||
          (rst_on_busy_d && owner == 2 && $urandom_range(0, 7) == 0);

    if (saw_i_done || !i_read) begin
      i_read = ($urandom_range(0, 99) < p_i);
      if (i_read) i_addr = $urandom & 32'hFFFF_FFE0;
    end else if ($urandom_range(0, 99) < 2) begin
      i_read = 1'b0;
    end

    if (saw_d_done || !(d_read || d_write)) begin
      if ($urandom_range(0, 99) < p_d) begin
        op      = $urandom_range(0, 9);
        d_write = (op < 5);
        d_read  = (op >= 5) || (op == 0);
        d_addr  = $urandom & 32'hFFFF_FFE0;
      end else begin
        d_read  = 1'b0;
        d_write = 1'b0;
      end
    end
    if ($urandom_range(0, 9) < 3) d_write_data = rand_line();

    mmu_read_data = rand_line();
    if (rst)             mmu_done = 1'b0;
    else if (owner != 0) mmu_done = ($urandom_range(0, 99) < 35);
    else                 mmu_done = ($urandom_range(0, 99) < 10);
  endtask

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic update_model();
    bit dreq;
    if (rst) begin
      owner = 0; blocked = 0; starve = 0; after_reset = 1'b1;
      exp_rd = 1'b0; exp_wr = 1'b0; exp_addr = '0; exp_wdata = '0;
      exp_ig = '0; exp_dg = '0; exp_iw = '0;
    end else begin
      after_reset = 1'b0;
      if (i_read && owner != 1) exp_iw = exp_iw + 32'd1;
      dreq = d_read || d_write;
      if (owner != 0) begin
        if (mmu_done) begin
          owner = 0; blocked = 1; exp_rd = 1'b0; exp_wr = 1'b0;
        end
      end else if (blocked > 0) begin
        blocked--;
      end else if (i_read && (!dreq || starve == STARVE_LIMIT)) begin
        owner = 1; exp_rd = 1'b1; exp_wr = 1'b0; exp_addr = i_addr;
        starve = 0; exp_ig = exp_ig + 32'd1;
      end else if (dreq) begin
        owner = 2; exp_wr = d_write; exp_rd = !d_write;
        exp_addr = d_addr; exp_wdata = d_write_data;
        if (i_read && starve < STARVE_LIMIT) starve++;
        exp_dg = exp_dg + 32'd1;
      end
    end
  endtask

  task automatic run_cycle(input int p_i, input int p_d, input int p_rst);
    @(posedge sys_clk);
    #1;
    checkOutput("mmu_read", mmu_read, exp_rd);
    checkOutput("mmu_write", mmu_write, exp_wr);
    if (owner != 0) checkOutput("mmu_addr", mmu_addr, exp_addr);
    if (owner == 2 && exp_wr) checkOutput("mmu_write_data", mmu_write_data, exp_wdata);
    if (after_reset) begin
      checkOutput("reset_addr", mmu_addr, '0);
      checkOutput("reset_wdata", mmu_write_data, '0);
    end
`ifdef ARB_PERF_CNT_EN
    checkOutput("perf_i_grants", perf_i_grants, exp_ig);
    checkOutput("perf_d_grants", perf_d_grants, exp_dg);
    checkOutput("perf_i_wait", perf_i_wait, exp_iw);
`endif
    applyStimulus(p_i, p_d, p_rst);
    #1;
    checkOutput("i_done", i_done, (owner == 1) && mmu_done && !rst);
    checkOutput("d_done", d_done, (owner == 2) && mmu_done && !rst);
    if (owner == 1 && mmu_done && !rst) checkOutput("i_read_data", i_read_data, mmu_read_data);
    if (owner == 2 && mmu_done && !rst) checkOutput("d_read_data", d_read_data, mmu_read_data);
    saw_i_done = i_done;
    saw_d_done = d_done;
    update_model();
  endtask

  initial begin
    i_read = 1'b0; i_addr = '0; d_read = 1'b0; d_write = 1'b0; d_addr = '0;
    d_write_data = '0; mmu_done = 1'b0; mmu_read_data = '0;
    owner = 0; blocked = 0; starve = 0;
    saw_i_done = 1'b0; saw_d_done = 1'b0; rst_on_busy_d = 1'b0;
    force_rst = 1'b1;
    applyStimulus(0, 0, 0);
    update_model();
    repeat (2) run_cycle(0, 0, 0);
    force_rst = 1'b0;
    repeat (400) run_cycle(30, 30, 3);
    repeat (300) run_cycle(100, 100, 0);
    rst_on_busy_d = 1'b1;
    repeat (300) run_cycle(40, 40, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
